// File: rtl/score_display.sv
// score_display
//   Reader side of the score bus. Converts the 7-bit binary score to three
//   BCD digits with a multi-cycle double-dabble sequence. It then scans them
//   onto a 4-digit common-anode seven-segment display.
//
//   Parameters:
//     REFRESH_DIV  clk cycles per digit slot (>= 2)
//
//   Ports:
//     clk    in   system clock, rising edge
//     rst    in   synchronous reset, active-low
//     score  in   [6:0] binary score 0..127, may change any cycle
//     seg    out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//     an     out  [3:0] digit anodes, active-low, an[0] = ones digit
//     dp     out  decimal point, active-low, always off (1)
//     busy   out  high while a conversion is in progress
//
//   Build option:
//     LEADING_ZERO_BLANK_EN  when defined, leading zero digits are blanked
//                            (segments dark, anode still driven). The ones
//                            digit is never blanked.

module score_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] score,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       busy
);

  localparam int            CW     = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] RC_MAX = CW'(REFRESH_DIV - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CONV  = 2'd1;
  localparam logic [1:0] LATCH = 2'd2;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Conversion state
  logic [1:0]  state;
  logic [6:0]  last_score;
  logic [18:0] shreg;     // {hund, tens, ones, binary}
  logic [2:0]  iter;
  logic [18:0] shadj;
  logic [18:0] shnext;

  // Display registers, updated only in LATCH
  logic [3:0]  bcd_ones;
  logic [3:0]  bcd_tens;
  logic [3:0]  bcd_hund;

  // Scan state
  logic [CW-1:0] rcnt;
  logic [1:0]    sel;
  logic [3:0]    slot_an;
  logic [6:0]    slot_seg;
  logic          blank_tens;
  logic          blank_hund;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // One double-dabble iteration: correct each BCD nibble, then shift left.
  always_comb begin
    shadj        = shreg;
    shadj[10:7]  = add3(shreg[10:7]);
    shadj[14:11] = add3(shreg[14:11]);
    shadj[18:15] = add3(shreg[18:15]);
    shnext       = shadj << 1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_score <= '0;
      shreg      <= '0;
      iter       <= '0;
      bcd_ones   <= '0;
      bcd_tens   <= '0;
      bcd_hund   <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (score != last_score) begin
            shreg      <= {12'b0, score};
            last_score <= score;
            iter       <= '0;
            state      <= CONV;
            busy       <= 1'b1;
          end
        end
        CONV: begin
          shreg <= shnext;
          iter  <= iter + 3'd1;
          if (iter == 3'd6) begin
            state <= LATCH;
          end
        end
        LATCH: begin
          bcd_ones <= shreg[10:7];
          bcd_tens <= shreg[14:11];
          bcd_hund <= shreg[18:15];
          state    <= IDLE;
          busy     <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    blank_hund = (bcd_hund == 4'd0);
    blank_tens = (bcd_hund == 4'd0) && (bcd_tens == 4'd0);
  end
`else
  always_comb begin
    blank_hund = 1'b0;
    blank_tens = 1'b0;
  end
`endif

  always_comb begin
    slot_an  = 4'b1111;
    slot_seg = SEG_OFF;
    case (sel)
      2'd0: begin
        slot_an  = 4'b1110;
        slot_seg = dec7(bcd_ones);
      end
      2'd1: begin
        slot_an  = 4'b1101;
        slot_seg = blank_tens ? SEG_OFF : dec7(bcd_tens);
      end
      2'd2: begin
        slot_an  = 4'b1011;
        slot_seg = blank_hund ? SEG_OFF : dec7(bcd_hund);
      end
      default: begin
        slot_an  = 4'b1111;
        slot_seg = SEG_OFF;
      end
    endcase
  end

  // Outputs are loaded from the current select on the wrap cycle, so the
  // ones digit first appears one full refresh period after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rcnt <= '0;
      sel  <= '0;
      seg  <= SEG_OFF;
      an   <= 4'b1111;
    end else if (rcnt == RC_MAX) begin
      rcnt <= '0;
      sel  <= sel + 2'd1;
      an   <= slot_an;
      seg  <= slot_seg;
    end else begin
      rcnt <= rcnt + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_score_display.sv
// Testbench for score_display: per-cycle comparison against a timing-level
// reference model, a table of scanned-digit vectors, hand sequences for
// busy timing, mid-conversion score changes and reset mid-conversion, and
// a randomized run.

module tb_score_display;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] score = 7'd0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  score_display #(.REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .rst   (rst),
    .score (score),
    .seg   (seg),
    .an    (an),
    .dp    (dp),
    .busy  (busy)
  );

  // Reference model state
  int         m_last, m_val, m_rem;
  int         m_ones, m_tens, m_hund;
  int         m_rc, m_sel;
  logic [6:0] m_seg;
  logic [3:0] m_an;
  logic       m_busy;

  typedef struct {
    logic [6:0] sc;
    int         o;
    int         t;
    int         h;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] dec(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] slot_seg(input int slot, input int o, input int t, input int h);
    bit bh, bt;
    bh = 1'b0;
    bt = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    bh = (h == 0);
    bt = (h == 0) && (t == 0);
`endif
    case (slot)
      0: return dec(o);
      1: return bt ? 7'b1111111 : dec(t);
      2: return bh ? 7'b1111111 : dec(h);
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] slot_an(input int slot);
    case (slot)
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b1111;
    endcase
  endfunction

  // Model: a conversion is a busy window of 8 cycles after the detecting
  // edge; digits appear at the end of it as plain decimal arithmetic.
  task automatic model_step(input logic r, input logic [6:0] s);
    if (!r) begin
      m_last = 0; m_val = 0; m_rem = 0;
      m_ones = 0; m_tens = 0; m_hund = 0;
      m_rc = 0; m_sel = 0;
      m_seg = 7'b1111111; m_an = 4'b1111;
    end else begin
      if (m_rc == DIV - 1) begin
        m_rc  = 0;
        m_an  = slot_an(m_sel);
        m_seg = slot_seg(m_sel, m_ones, m_tens, m_hund);
        m_sel = (m_sel + 1) % 4;
      end else begin
        m_rc++;
      end
      if (m_rem == 0) begin
        if (int'(s) != m_last) begin
          m_last = int'(s);
          m_val  = int'(s);
          m_rem  = 8;
        end
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_ones = m_val % 10;
          m_tens = (m_val / 10) % 10;
          m_hund = m_val / 100;
        end
      end
    end
    m_busy = (m_rem != 0);
  endtask

  task automatic step(input logic r, input logic [6:0] s);
    rst   = r;
    score = s;
    @(posedge clk);
    model_step(r, s);
    #1;
    chk("seg", 32'(seg), 32'(m_seg));
    chk("an", 32'(an), 32'(m_an));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("dp", 32'(dp), 32'd1);
  endtask

  // Run one full scan and compare what each anode slot shows.
  task automatic check_scan(input int o, input int t, input int h);
    int so, st, sh, sd;
    so = -1; st = -1; sh = -1; sd = -1;
    repeat (4 * DIV + 1) begin
      step(1'b1, score);
      case (an)
        4'b1110: so = int'(seg);
        4'b1101: st = int'(seg);
        4'b1011: sh = int'(seg);
        4'b1111: sd = int'(seg);
        default: ;
      endcase
    end
    chk("scan_ones", 32'(so), 32'(slot_seg(0, o, t, h)));
    chk("scan_tens", 32'(st), 32'(slot_seg(1, o, t, h)));
    chk("scan_hund", 32'(sh), 32'(slot_seg(2, o, t, h)));
    chk("scan_dark", 32'(sd), 32'h7f);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt, bound, rises;
    logic pb;

    tbl[0] = '{7'd0,   0, 0, 0};
    tbl[1] = '{7'd7,   7, 0, 0};
    tbl[2] = '{7'd127, 7, 2, 1};
    tbl[3] = '{7'd45,  5, 4, 0};
    tbl[4] = '{7'd100, 0, 0, 1};
    tbl[5] = '{7'd5,   5, 0, 0};
    tbl[6] = '{7'd99,  9, 9, 0};
    tbl[7] = '{7'd10,  0, 1, 0};

    // Reset with score 0
    repeat (5) step(1'b0, 7'd0);
    chk("rst_seg", 32'(seg), 32'h7f);
    chk("rst_an", 32'(an), 32'hf);
    chk("rst_busy", 32'(busy), 32'd0);
    cnt = 0;
    repeat (10) begin
      step(1'b1, 7'd0);
      if (busy) cnt++;
    end
    chk("idle_no_busy", 32'(cnt), 32'd0);
    check_scan(0, 0, 0);

    // Single conversion 0 -> 7: busy rises on the detecting edge, lasts 8
    step(1'b1, 7'd7);
    chk("busy_rise", 32'(busy), 32'd1);
    cnt = 1;
    bound = 0;
    while (busy && bound < 20) begin
      step(1'b1, 7'd7);
      if (busy) cnt++;
      bound++;
    end
    chk("busy_len", 32'(cnt), 32'd8);
    check_scan(7, 0, 0);

    // Change during conversion: 45 then 99 three cycles later
    step(1'b1, 7'd0);
    repeat (12) step(1'b1, 7'd0);
    pb = busy;
    rises = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, (i < 3) ? 7'd45 : 7'd99);
      if (busy && !pb) rises++;
      pb = busy;
    end
    chk("rerun_count", 32'(rises), 32'd2);
    check_scan(9, 9, 0);

    // Reset during CONV iteration 4
    repeat (12) step(1'b1, 7'd0);
    step(1'b1, 7'd88);
    repeat (3) step(1'b1, 7'd88);
    chk("pre_abort_busy", 32'(busy), 32'd1);
    step(1'b0, 7'd88);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_seg", 32'(seg), 32'h7f);
    check_scan(0, 0, 0);
    repeat (12) step(1'b1, 7'd88);
    check_scan(8, 8, 0);

    // Table vectors
    for (int k = 0; k < 8; k++) begin
      repeat (12) step(1'b1, tbl[k].sc);
      check_scan(tbl[k].o, tbl[k].t, tbl[k].h);
    end

    // Randomized run against the model
    for (int i = 0; i < 600; i++) begin
      logic [6:0] s;
      logic       r;
      s = score;
      if ($urandom_range(0, 9) == 0) s = 7'($urandom_range(0, 127));
      r = ($urandom_range(0, 149) != 0);
      step(r, s);
    end
    repeat (12) step(1'b1, score);
    check_scan(int'(score) % 10, (int'(score) / 10) % 10, int'(score) / 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
